// File: rtl/keccak_squeeze_if.sv
// keccak_squeeze_if: state intake and lane output handshakes of the sponge squeeze unit
// slave side (the squeeze unit) receives state_in/state_valid/lane_ready and drives the rest
interface keccak_squeeze_if #(
    parameter int l = 6
);
    localparam int w = 2 ** l;
    localparam int b = 25 * w;
    logic [b-1:0] state_in;
    logic         state_valid;
    logic         state_ready;
    logic         perm_req;
    logic [w-1:0] lane_out;
    logic         lane_valid;
    logic         lane_ready;
    logic         lane_last;
    logic         busy;
    modport master (
        output state_in, state_valid, lane_ready,
        input  state_ready, perm_req, lane_out, lane_valid, lane_last, busy
    );
    modport slave (
        input  state_in, state_valid, lane_ready,
        output state_ready, perm_req, lane_out, lane_valid, lane_last, busy
    );
endinterface

// File: rtl/keccak_squeeze.sv
// keccak_squeeze: streams the rate lanes of permuted states out as w-bit lanes, requesting permutations as needed
// ports: clk, reset (async, active-high), s (keccak_squeeze_if.slave: state intake, lane output, perm_req, busy)
module keccak_squeeze #(
    parameter int l          = 6,
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4
) (
    input logic clk,
    input logic reset,
    keccak_squeeze_if.slave s
);
    localparam int w  = 2 ** l;
    localparam int b  = 25 * w;
    localparam int iw = RATE_LANES > 1 ? $clog2(RATE_LANES) : 1;
    localparam int cw = $clog2(OUT_LANES + 1);
    localparam logic [iw-1:0] idx_end = iw'(RATE_LANES - 1);
    localparam logic [cw-1:0] cnt_end = cw'(OUT_LANES - 1);
    typedef enum logic [1:0] {IDLE, EMIT, WAIT_PERM} st_t;
    st_t          st;
    logic [b-1:0] sreg;
    logic [iw-1:0] lane_idx;
    logic [cw-1:0] out_cnt;
    logic ready_q, perm_q, valid_q, last_q, busy_q;
    int   pos;
    // emission index n maps to lane (x=n%5, y=n/5), stored at lane slot 5x+y
    always_comb pos = 5 * (int'(lane_idx) % 5) + int'(lane_idx) / 5;
    assign s.lane_out    = sreg[w*pos +: w];
    assign s.state_ready = ready_q;
    assign s.perm_req    = perm_q;
    assign s.lane_valid  = valid_q;
    assign s.lane_last   = last_q;
    assign s.busy        = busy_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            sreg     <= '0;
            lane_idx <= '0;
            out_cnt  <= '0;
            ready_q  <= 1'b1;
            perm_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (st)
                IDLE: if (s.state_valid) begin
                    sreg     <= s.state_in;
                    lane_idx <= '0;
                    out_cnt  <= '0;
                    st       <= EMIT;
                    ready_q  <= 1'b0;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b1;
                    last_q   <= (OUT_LANES == 1);
                end
                EMIT: if (s.lane_ready) begin
                    if (last_q) begin
                        st      <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (lane_idx == idx_end) begin
                        out_cnt <= out_cnt + 1'b1;
                        st      <= WAIT_PERM;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        perm_q  <= 1'b1;
                    end else begin
                        lane_idx <= lane_idx + 1'b1;
                        out_cnt  <= out_cnt + 1'b1;
                        last_q   <= (out_cnt + 1'b1 == cnt_end);
                    end
                end
                WAIT_PERM: if (s.state_valid) begin
                    sreg     <= s.state_in;
                    lane_idx <= '0;
                    st       <= EMIT;
                    ready_q  <= 1'b0;
                    valid_q  <= 1'b1;
                    perm_q   <= 1'b0;
                    last_q   <= (out_cnt == cnt_end);
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keccak_squeeze.sv
// tb_keccak_squeeze: table vectors, directed corner sequences and randomized sessions against a lane-order model
module tb_keccak_squeeze;
    localparam int L = 6;
    localparam int W = 64;
    localparam int B = 1600;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    logic [B-1:0] state_in = '0;
    logic state_valid = 1'b0;
    logic lane_ready = 1'b0;
    keccak_squeeze_if #(.l(L)) if0 ();
    keccak_squeeze_if #(.l(L)) if1 ();
    keccak_squeeze_if #(.l(L)) if2 ();
    assign if0.state_in = state_in;
    assign if1.state_in = state_in;
    assign if2.state_in = state_in;
    assign if0.state_valid = state_valid;
    assign if1.state_valid = state_valid;
    assign if2.state_valid = state_valid;
    assign if0.lane_ready = lane_ready;
    assign if1.lane_ready = lane_ready;
    assign if2.lane_ready = lane_ready;
    keccak_squeeze #(.l(L), .RATE_LANES(17), .OUT_LANES(4))  u0 (.clk(clk), .reset(reset), .s(if0));
    keccak_squeeze #(.l(L), .RATE_LANES(17), .OUT_LANES(20)) u1 (.clk(clk), .reset(reset), .s(if1));
    keccak_squeeze #(.l(L), .RATE_LANES(1),  .OUT_LANES(3))  u2 (.clk(clk), .reset(reset), .s(if2));
    int cfg = 0;
    int rate_of [3] = '{17, 17, 1};
    int out_of  [3] = '{4, 20, 3};
    logic [W-1:0] o_lane;
    logic o_valid, o_last, o_perm, o_sready, o_busy;
    assign o_lane   = cfg == 0 ? if0.lane_out    : cfg == 1 ? if1.lane_out    : if2.lane_out;
    assign o_valid  = cfg == 0 ? if0.lane_valid  : cfg == 1 ? if1.lane_valid  : if2.lane_valid;
    assign o_last   = cfg == 0 ? if0.lane_last   : cfg == 1 ? if1.lane_last   : if2.lane_last;
    assign o_perm   = cfg == 0 ? if0.perm_req    : cfg == 1 ? if1.perm_req    : if2.perm_req;
    assign o_sready = cfg == 0 ? if0.state_ready : cfg == 1 ? if1.state_ready : if2.state_ready;
    assign o_busy   = cfg == 0 ? if0.busy        : cfg == 1 ? if1.busy        : if2.busy;
    int total = 0;
    int bad = 0;
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cfg %0d, t=%0t)", name, act, exp, cfg, $time);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [B-1:0] seq_state(input int base);
        logic [B-1:0] s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                s[W*(5*x+y) +: W] = W'(base + x + 5 * y);
        return s;
    endfunction
    function automatic logic [B-1:0] rand_state();
        logic [B-1:0] s;
        for (int i = 0; i < B / 32; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction
    function automatic logic [W-1:0] lane_of(input logic [B-1:0] s, input int n);
        int x, y;
        x = n % 5;
        y = n / 5;
        return s[W*(5*x+y) +: W];
    endfunction
    task automatic check_reset_vals(input string tag);
        chk({tag, "_sready"}, W'(o_sready), W'(1));
        chk({tag, "_perm"},   W'(o_perm),   W'(0));
        chk({tag, "_valid"},  W'(o_valid),  W'(0));
        chk({tag, "_last"},   W'(o_last),   W'(0));
        chk({tag, "_busy"},   W'(o_busy),   W'(0));
        chk({tag, "_lane"},   o_lane,       W'(0));
    endtask
    task automatic do_reset(input int c);
        cfg = c;
        state_valid = 1'b0;
        lane_ready = 1'b0;
        reset = 1'b1;
        tick;
        check_reset_vals("rst");
        tick;
        reset = 1'b0;
    endtask
    typedef struct {int sv; int lr; int v; int ln; int last; int sr; int bz;} vec_t;
    vec_t tbl [13];
    task automatic run_random(input int c);
        logic [B-1:0] sts [$];
        logic [B-1:0] nx;
        int k, cyc, r, o;
        bit ev, ep, esr;
        r = rate_of[c];
        o = out_of[c];
        k = 0;
        cyc = 0;
        do_reset(c);
        while (k < o && cyc < 500) begin
            ev  = sts.size() > 0 && k < sts.size() * r;
            ep  = sts.size() > 0 && k == sts.size() * r;
            esr = sts.size() == 0 || ep;
            chk("rnd_valid",  W'(o_valid),  W'(ev));
            chk("rnd_perm",   W'(o_perm),   W'(ep));
            chk("rnd_sready", W'(o_sready), W'(esr));
            nx = rand_state();
            state_in = nx;
            state_valid = 1'($urandom_range(0, 1));
            lane_ready = $urandom_range(0, 3) != 0;
            if (ev && lane_ready) begin
                chk("rnd_lane", o_lane, lane_of(sts[k/r], k % r));
                chk("rnd_last", W'(o_last), W'(k == o - 1));
                k++;
            end
            if (state_valid && esr) sts.push_back(nx);
            tick;
            cyc++;
        end
        state_valid = 1'b0;
        if (k < o) begin
            total++;
            bad++;
            $display("FAIL rnd_timeout: got %0d lanes expected %0d", k, o);
        end
        chk("rnd_end_sready", W'(o_sready), W'(1));
        chk("rnd_end_busy",   W'(o_busy),   W'(0));
    endtask
    initial begin
        logic [B-1:0] sarr [3];
        logic [B-1:0] s;
        //            sv lr  v  ln last sr bz
        tbl[0]  = '{1, 1, 1, 0, 0, 0, 1};
        tbl[1]  = '{0, 1, 1, 1, 0, 0, 1};
        tbl[2]  = '{0, 1, 1, 2, 0, 0, 1};
        tbl[3]  = '{0, 1, 1, 3, 1, 0, 1};
        tbl[4]  = '{0, 1, 0, 0, 0, 1, 0};
        tbl[5]  = '{1, 1, 1, 0, 0, 0, 1};
        tbl[6]  = '{0, 1, 1, 1, 0, 0, 1};
        tbl[7]  = '{0, 0, 1, 1, 0, 0, 1};
        tbl[8]  = '{0, 0, 1, 1, 0, 0, 1};
        tbl[9]  = '{0, 1, 1, 2, 0, 0, 1};
        tbl[10] = '{0, 0, 1, 2, 0, 0, 1};
        tbl[11] = '{0, 1, 1, 3, 1, 0, 1};
        tbl[12] = '{0, 1, 0, 0, 0, 1, 0};
        // basic session and backpressure
        do_reset(0);
        state_in = seq_state(0);
        for (int i = 0; i < 13; i++) begin
            state_valid = 1'(tbl[i].sv);
            lane_ready = 1'(tbl[i].lr);
            tick;
            chk("tbl_valid",  W'(o_valid),  W'(tbl[i].v));
            chk("tbl_last",   W'(o_last),   W'(tbl[i].last));
            chk("tbl_sready", W'(o_sready), W'(tbl[i].sr));
            chk("tbl_busy",   W'(o_busy),   W'(tbl[i].bz));
            chk("tbl_perm",   W'(o_perm),   W'(0));
            if (tbl[i].v != 0) chk("tbl_lane", o_lane, W'(tbl[i].ln));
        end
        // state_valid held with a different state throughout EMIT
        do_reset(0);
        state_in = seq_state(0);
        state_valid = 1'b1;
        lane_ready = 1'b1;
        tick;
        chk("hold_lane0", o_lane, W'(0));
        state_in = rand_state();
        for (int n = 1; n < 4; n++) begin
            tick;
            chk("hold_lane", o_lane, W'(n));
            chk("hold_sready", W'(o_sready), W'(0));
        end
        state_valid = 1'b0;
        tick;
        chk("hold_end_busy", W'(o_busy), W'(0));
        // multi-block session
        do_reset(1);
        state_in = seq_state(0);
        state_valid = 1'b1;
        lane_ready = 1'b1;
        tick;
        state_valid = 1'b0;
        for (int n = 0; n < 17; n++) begin
            chk("mb_lane", o_lane, W'(n));
            chk("mb_last", W'(o_last), W'(0));
            tick;
        end
        chk("mb_perm",   W'(o_perm),   W'(1));
        chk("mb_valid",  W'(o_valid),  W'(0));
        chk("mb_sready", W'(o_sready), W'(1));
        chk("mb_busy",   W'(o_busy),   W'(1));
        repeat (5) begin
            tick;
            chk("mb_perm_hold", W'(o_perm), W'(1));
        end
        state_in = seq_state(100);
        state_valid = 1'b1;
        tick;
        state_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            chk("mb2_lane", o_lane, W'(100 + n));
            chk("mb2_last", W'(o_last), W'(n == 2));
            chk("mb2_perm", W'(o_perm), W'(0));
            tick;
        end
        chk("mb_end_perm",   W'(o_perm),   W'(0));
        chk("mb_end_sready", W'(o_sready), W'(1));
        chk("mb_end_busy",   W'(o_busy),   W'(0));
        // reset in the middle of EMIT
        do_reset(0);
        state_in = seq_state(0);
        state_valid = 1'b1;
        lane_ready = 1'b1;
        tick;
        state_valid = 1'b0;
        tick;
        tick;
        chk("mid_lane2", o_lane, W'(2));
        reset = 1'b1;
        #1;
        check_reset_vals("mid_rst");
        tick;
        reset = 1'b0;
        s = rand_state();
        state_in = s;
        state_valid = 1'b1;
        tick;
        state_valid = 1'b0;
        chk("mid_new_lane0", o_lane, lane_of(s, 0));
        chk("mid_new_valid", W'(o_valid), W'(1));
        tick;
        chk("mid_new_lane1", o_lane, lane_of(s, 1));
        // single-lane rate, three lanes out
        do_reset(2);
        lane_ready = 1'b1;
        for (int k = 0; k < 3; k++) sarr[k] = rand_state();
        state_in = sarr[0];
        state_valid = 1'b1;
        tick;
        state_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("r1_lane", o_lane, lane_of(sarr[k], 0));
            chk("r1_last", W'(o_last), W'(k == 2));
            tick;
            if (k < 2) begin
                chk("r1_perm",  W'(o_perm),  W'(1));
                chk("r1_valid", W'(o_valid), W'(0));
                state_in = sarr[k+1];
                state_valid = 1'b1;
                tick;
                state_valid = 1'b0;
            end
        end
        chk("r1_end_perm", W'(o_perm), W'(0));
        chk("r1_end_busy", W'(o_busy), W'(0));
        // randomized sessions against the lane-order model
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 6; r++) run_random(c);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keccak_squeeze.md
# keccak_squeeze

Sponge squeeze unit for the Keccak datapath. It accepts a fully permuted b-bit state from the round pipeline and streams the rate portion out as w-bit lanes over a valid/ready handshake. When the rate is exhausted before the requested output length is reached, it requests another permutation and resumes on the next state. It sits at the output end of the sponge, opposite the absorb path that feeds the theta/rho/pi/chi/iota rounds.

## Interface
- l, 6, log2 of lane width
- w, 2**l, lane width in bits
- b, 25*w, state width in bits
- RATE_LANES, 17, lanes of the state in the rate; legal range 1..24
- OUT_LANES, 4, total lanes emitted per squeeze session; must be at least 1

- clk  in  1  clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high reset
- state_in  in  b  permuted state; lane (x,y) occupies bits w*(5*x+y)+:w
- state_valid  in  1  state_in is valid
- state_ready  out  1  block can accept a state this cycle
- perm_req  out  1  level request for the next permutation of the previously delivered state
- lane_out  out  w  current output lane
- lane_valid  out  1  lane_out is valid
- lane_ready  in  1  downstream accepts lane_out
- lane_last  out  1  lane_out is the final lane of the session
- busy  out  1  a session is in progress

## Operation
- The FSM has three states: IDLE, EMIT, WAIT_PERM.
- IDLE: state_ready=1, busy=0. On state_valid, capture state_in into a b-bit register, clear lane_idx and out_cnt, and go to EMIT.
- EMIT: lane_valid=1, busy=1, state_ready=0.
  - lane_out is the captured lane at emission index n=lane_idx, with x=n%5 and y=n/5. It therefore reads bits w*(5*(n%5)+n/5)+:w.
  - lane_last=1 when out_cnt==OUT_LANES-1.
- A lane handshake occurs on lane_valid && lane_ready:
  - If lane_last: go to IDLE.
  - Else if lane_idx==RATE_LANES-1: increment out_cnt and go to WAIT_PERM.
  - Else: increment lane_idx and out_cnt, and stay in EMIT.
- WAIT_PERM: perm_req=1, state_ready=1, busy=1, lane_valid=0. On state_valid, capture the new state, set lane_idx=0 (out_cnt is kept), and go to EMIT.
- lane_idx is ceil(log2(RATE_LANES)) bits wide. out_cnt is ceil(log2(OUT_LANES+1)) bits wide. Neither counter ever wraps inside a session.
- state_valid outside IDLE/WAIT_PERM is ignored and nothing is captured.
- lane_ready while lane_valid=0 has no effect.
- Capacity lanes (emission index >= RATE_LANES) are never output.

## Timing
- Reset values while reset is asserted, with the FSM in IDLE:
  - state_ready=1
  - perm_req=0, lane_valid=0, lane_last=0, busy=0, lane_out=0
  - state register and counters = 0
- Reset mid-session aborts immediately. Captured data is discarded, and the next session starts from lane 0.
- A state accepted at edge N presents lane 0 with lane_valid=1 in the cycle after edge N, so latency is 1 cycle.
- Throughput is 1 lane per cycle while lane_ready=1.
- lane_out, lane_last and lane_valid hold stable while lane_valid && !lane_ready. No lane is skipped or duplicated.
- The handshake on the last lane of the rate at edge M puts perm_req=1 in the cycle after M. perm_req stays high until the new state is accepted and drops in the cycle after that acceptance.
- The handshake on the final lane at edge M gives state_ready=1 and busy=0 in the cycle after M.
- There is no bubble between lanes within one rate block.
- All outputs are registered or decoded from registers only. There is no combinational path from inputs to outputs.

## Test plan
- Basic session, OUT_LANES=4, RATE_LANES=17. Load a state whose lane (x,y) holds the value x+5y, with lane_ready=1. Expect lane_out 0,1,2,3 on 4 consecutive cycles, lane_last only on 3, perm_req never asserted, and state_ready=1 the cycle after lane 3.
- Backpressure, same setup. Drive lane_ready with the pattern 1,0,0,1,0,1,1. Expect each value held during stall cycles and the accepted sequence to be exactly 0,1,2,3.
- Multi-block, OUT_LANES=20. After lanes 0..16, expect perm_req=1 and lane_valid=0. Hold off for 5 cycles, then deliver a second state with lane (x,y) holding 100+x+5y. Expect 100,101,102 with lane_last on 102 and perm_req=0 afterwards.
- Reset mid-EMIT: assert reset right after lane 1 is accepted. Expect all reset values immediately. A new state must then restart emission at lane 0.
- Hold state_valid=1 with a different state_in throughout EMIT. Expect state_ready=0 and an unchanged lane_out sequence.
- Edge case, RATE_LANES=1 and OUT_LANES=3. Expect perm_req to assert after each of the first two lanes, with each emitted lane being lane (0,0) of the newly delivered state.
